bsg_chip_mem_io_arbiter: RTL and testbench
==========================================

# bsg_chip_mem_io_arbiter

Shares one off-chip command/response channel between the two outbound command streams of the single-core BlackParrot chip (I/O commands and memory commands). It round-robin arbitrates commands into a one-entry output register, records the source of each issued command in an in-order tag FIFO, and steers returning responses back to the originating stream. It sits between the core's io_cmd/mem_cmd/io_resp/mem_resp ports and the chip-level memory link.

## Interface
- msg_width_p, 0 (must be set; cce_mem_msg_width_lp), command/response message width
- els_p, 8, max commands outstanding (in output register plus issued and awaiting response); power of two, ≥2
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- io_cmd_i / io_cmd_v_i / io_cmd_ready_o  in/in/out  msg_width_p/1/1  I/O command input, ready/valid
- mem_cmd_i / mem_cmd_v_i / mem_cmd_ready_o  in/in/out  msg_width_p/1/1  memory command input, ready/valid
- cmd_o / cmd_v_o / cmd_ready_i  out/out/in  msg_width_p/1/1  merged command output, ready/valid
- resp_i / resp_v_i / resp_yumi_o  in/in/out  msg_width_p/1/1  merged response input, valid/yumi
- io_resp_o / io_resp_v_o / io_resp_ready_i  out/out/in  msg_width_p/1/1  I/O response output
- mem_resp_o / mem_resp_v_o / mem_resp_ready_i  out/out/in  msg_width_p/1/1  memory response output
- err_o  out  1  sticky: response arrived with no outstanding command
- perf_io_cnt_o, perf_mem_cnt_o, perf_stall_cnt_o  out  32 each  performance counters (see Configuration)

## Operation
- Occupancy = output register valid (0/1) + tag FIFO count. Accept allowed when occupancy < els_p and (register empty or register draining this cycle).
- Arbitration: if exactly one input valid, grant it; if both, grant the one not granted last. Last-grant pointer resets to mem, so io wins the first tie. Pointer updates only on an accepted grant.
- Ready outputs: ready_o = accept allowed and granted; never depends on the other input's ready.
- Accepted message and source bit load the output register; cmd_v_o = register valid.
- On cmd_v_o & cmd_ready_i: push source into tag FIFO; register clears unless reloaded same cycle.
- Responses are in order. FIFO head selects destination; io_resp_o/mem_resp_o = resp_i (both driven); only selected v_o = resp_v_i & FIFO non-empty.
- resp_yumi_o = resp_v_i & FIFO non-empty & selected ready_i; pop FIFO on yumi.
- resp_v_i with FIFO empty: not yumied, err_o set until reset.
- Same-cycle push and pop: count unchanged, both take effect.

## Timing
- Command latency: 1 cycle input accept → cmd_v_o. Back-to-back throughput 1/cycle while cmd_ready_i high and occupancy allows.
- Response path: combinational, 0 cycles.
- Reset values: cmd_v_o=0, io_resp_v_o=0, mem_resp_v_o=0, resp_yumi_o=0, io_cmd_ready_o=0 and mem_cmd_ready_o=0 during reset, err_o=0, counters=0, FIFO empty, pointer=mem.
- Reset mid-operation: register and FIFO cleared immediately; responses to pre-reset commands then set err_o.
- Occupancy = els_p: both ready_o low until a pop reduces count (pop-same-cycle does not permit accept).

## Configuration
- BSG_CHIP_MEM_IO_ARB_PERF_EN defined: perf_io_cnt_o/perf_mem_cnt_o count accepted io/mem commands; perf_stall_cnt_o counts cycles with cmd_v_o & ~cmd_ready_i; all saturate at 2^32-1.
- Undefined: counters not built, all three outputs tied to 0. Ports identical either way.

## Structure
- bsg_chip_pkg: enum mem_io_src_e {e_src_io=0, e_src_mem=1}.
- Sub-module bsg_chip_mem_io_tag_fifo: 1-bit-wide, els_p-deep, 1r1w, count output, push/pop same cycle allowed.

## Test plan
- Only io_cmd_v_i, 3 messages, cmd_ready_i=1 → cmd_o issues all 3 on consecutive cycles, 1-cycle latency; responses route to io_resp_o only.
- Both inputs valid continuously after reset → grants alternate io, mem, io, mem; tag FIFO order matches; responses route accordingly.
- cmd_ready_i=1, responses withheld, els_p=8 → exactly 8 accepted, then both ready_o low; one yumi'd response allows one more.
- Response with mem_resp_ready_i=0 at FIFO head mem → resp_yumi_o=0, FIFO unchanged, later io-destined responses stall (in order).
- resp_v_i=1 with no outstanding command → resp_yumi_o=0, err_o=1 held until reset_i.
- With macro: hold cmd_ready_i=0 for 5 cycles with cmd_v_o=1 → perf_stall_cnt_o=5; without macro all counters read 0.

Source files
------------

// File: rtl/bsg_chip_pkg.sv
// Shared types for the chip-level memory/IO command arbiter.
package bsg_chip_pkg;

  // Originating command stream of an issued command
  typedef enum logic {
    e_src_io  = 1'b0,
    e_src_mem = 1'b1
  } mem_io_src_e;

  localparam int unsigned perf_cnt_width_lp = 32;

endpackage

// File: rtl/bsg_chip_mem_io_tag_fifo.sv
// In-order FIFO of command sources; one entry per issued, unanswered command.
module bsg_chip_mem_io_tag_fifo
  import bsg_chip_pkg::*;
#(
  parameter int unsigned els_p = 8,
  localparam int unsigned ptr_width_lp = $clog2(els_p),
  localparam int unsigned cnt_width_lp = $clog2(els_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    push_i,
  input  mem_io_src_e             data_i,
  input  logic                    pop_i,
  output mem_io_src_e             data_o,
  output logic [cnt_width_lp-1:0] count_o,
  output logic                    empty_o
);

  logic [els_p-1:0]        mem_r;
  logic [ptr_width_lp-1:0] wr_ptr_r;
  logic [ptr_width_lp-1:0] rd_ptr_r;
  logic [cnt_width_lp-1:0] count_r;

  // Storage, pointers (wrap naturally, depth is a power of two) and count
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mem_r    <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_i) begin
        mem_r[wr_ptr_r] <= data_i;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      if (push_i & ~pop_i) begin
        count_r <= count_r + 1'b1;
      end else if (pop_i & ~push_i) begin
        count_r <= count_r - 1'b1;
      end
    end
  end

  assign data_o  = mem_io_src_e'(mem_r[rd_ptr_r]);
  assign count_o = count_r;
  assign empty_o = (count_r == '0);

endmodule

// File: rtl/bsg_chip_mem_io_arbiter.sv
// Round-robin merge of io/mem command streams onto one link, with in-order
// response steering back to the originating stream.
// Optional performance counters: define BSG_CHIP_MEM_IO_ARB_PERF_EN.
module bsg_chip_mem_io_arbiter
  import bsg_chip_pkg::*;
#(
  parameter int unsigned msg_width_p = 0,
  parameter int unsigned els_p       = 8,
  localparam int unsigned msg_width_lp = (msg_width_p == 0) ? 1 : msg_width_p
) (
  input  logic                    clk_i,
  input  logic                    reset_i,

  input  logic [msg_width_lp-1:0] io_cmd_i,
  input  logic                    io_cmd_v_i,
  output logic                    io_cmd_ready_o,

  input  logic [msg_width_lp-1:0] mem_cmd_i,
  input  logic                    mem_cmd_v_i,
  output logic                    mem_cmd_ready_o,

  output logic [msg_width_lp-1:0] cmd_o,
  output logic                    cmd_v_o,
  input  logic                    cmd_ready_i,

  input  logic [msg_width_lp-1:0] resp_i,
  input  logic                    resp_v_i,
  output logic                    resp_yumi_o,

  output logic [msg_width_lp-1:0] io_resp_o,
  output logic                    io_resp_v_o,
  input  logic                    io_resp_ready_i,

  output logic [msg_width_lp-1:0] mem_resp_o,
  output logic                    mem_resp_v_o,
  input  logic                    mem_resp_ready_i,

  output logic                    err_o,

  output logic [31:0]             perf_io_cnt_o,
  output logic [31:0]             perf_mem_cnt_o,
  output logic [31:0]             perf_stall_cnt_o
);

  localparam int unsigned cnt_width_lp = $clog2(els_p + 1);
  localparam int unsigned occ_width_lp = $clog2(els_p + 2);

  logic [msg_width_lp-1:0] cmd_data_r;
  logic                    cmd_v_r;
  mem_io_src_e             cmd_src_r;
  mem_io_src_e             last_r;
  logic                    err_r;

  logic [cnt_width_lp-1:0] tag_count;
  mem_io_src_e             tag_head;
  logic                    tag_empty;

  logic [occ_width_lp-1:0] occupancy;
  logic                    drain;
  logic                    accept_ok;
  logic                    grant_io;
  logic                    grant_mem;
  logic                    accept;
  logic                    resp_has_tag;
  logic                    head_io;

  assign occupancy = occ_width_lp'(cmd_v_r) + occ_width_lp'(tag_count);
  assign drain     = cmd_v_r & cmd_ready_i;
  assign accept_ok = ~reset_i & (occupancy < occ_width_lp'(els_p)) & (~cmd_v_r | cmd_ready_i);

  // Round-robin grant: on a tie the stream not granted last wins
  always_comb begin
    grant_io  = 1'b0;
    grant_mem = 1'b0;
    if (io_cmd_v_i & mem_cmd_v_i) begin
      if (last_r == e_src_mem) grant_io  = 1'b1;
      else                     grant_mem = 1'b1;
    end else begin
      grant_io  = io_cmd_v_i;
      grant_mem = mem_cmd_v_i;
    end
  end

  assign io_cmd_ready_o  = accept_ok & grant_io;
  assign mem_cmd_ready_o = accept_ok & grant_mem;
  assign accept          = accept_ok & (grant_io | grant_mem);

  // One-entry output register and last-grant pointer
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cmd_data_r <= '0;
      cmd_v_r    <= 1'b0;
      cmd_src_r  <= e_src_io;
      last_r     <= e_src_mem;
    end else if (accept) begin
      cmd_data_r <= grant_io ? io_cmd_i : mem_cmd_i;
      cmd_v_r    <= 1'b1;
      cmd_src_r  <= grant_io ? e_src_io : e_src_mem;
      last_r     <= grant_io ? e_src_io : e_src_mem;
    end else if (drain) begin
      cmd_v_r    <= 1'b0;
    end
  end

  assign cmd_o   = cmd_data_r;
  assign cmd_v_o = cmd_v_r;

  bsg_chip_mem_io_tag_fifo #(
    .els_p(els_p)
  ) tag_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .push_i (drain),
    .data_i (cmd_src_r),
    .pop_i  (resp_yumi_o),
    .data_o (tag_head),
    .count_o(tag_count),
    .empty_o(tag_empty)
  );

  assign resp_has_tag = resp_v_i & ~tag_empty;
  assign head_io      = (tag_head == e_src_io);
  assign io_resp_o    = resp_i;
  assign mem_resp_o   = resp_i;
  assign io_resp_v_o  = resp_has_tag & head_io;
  assign mem_resp_v_o = resp_has_tag & ~head_io;
  assign resp_yumi_o  = resp_has_tag & (head_io ? io_resp_ready_i : mem_resp_ready_i);

  // Sticky flag: a response arrived with nothing outstanding
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                   err_r <= 1'b0;
    else if (resp_v_i & tag_empty) err_r <= 1'b1;
  end

  assign err_o = err_r;

`ifdef BSG_CHIP_MEM_IO_ARB_PERF_EN
  logic [perf_cnt_width_lp-1:0] io_cnt_r;
  logic [perf_cnt_width_lp-1:0] mem_cnt_r;
  logic [perf_cnt_width_lp-1:0] stall_cnt_r;

  // Saturating accept and back-pressure counters
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      io_cnt_r    <= '0;
      mem_cnt_r   <= '0;
      stall_cnt_r <= '0;
    end else begin
      if (accept & grant_io & ~(&io_cnt_r))       io_cnt_r    <= io_cnt_r + 1'b1;
      if (accept & grant_mem & ~(&mem_cnt_r))     mem_cnt_r   <= mem_cnt_r + 1'b1;
      if (cmd_v_r & ~cmd_ready_i & ~(&stall_cnt_r)) stall_cnt_r <= stall_cnt_r + 1'b1;
    end
  end

  assign perf_io_cnt_o    = io_cnt_r;
  assign perf_mem_cnt_o   = mem_cnt_r;
  assign perf_stall_cnt_o = stall_cnt_r;
`else
  assign perf_io_cnt_o    = '0;
  assign perf_mem_cnt_o   = '0;
  assign perf_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bsg_chip_mem_io_arbiter.sv
// Randomized bench for bsg_chip_mem_io_arbiter against a queue-based model.
module tb_bsg_chip_mem_io_arbiter;

  localparam int W   = 16;
  localparam int ELS = 8;
`ifdef BSG_CHIP_MEM_IO_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_i = 1'b1;
  logic [W-1:0] io_cmd_i = '0, mem_cmd_i = '0, resp_i = '0;
  logic         io_cmd_v_i = 1'b0, mem_cmd_v_i = 1'b0, cmd_ready_i = 1'b0;
  logic         resp_v_i = 1'b0, io_resp_ready_i = 1'b0, mem_resp_ready_i = 1'b0;
  logic [W-1:0] cmd_o, io_resp_o, mem_resp_o;
  logic         io_cmd_ready_o, mem_cmd_ready_o, cmd_v_o, resp_yumi_o;
  logic         io_resp_v_o, mem_resp_v_o, err_o;
  logic [31:0]  perf_io_cnt_o, perf_mem_cnt_o, perf_stall_cnt_o;

  always #5 clk = ~clk;

  bsg_chip_mem_io_arbiter #(.msg_width_p(W), .els_p(ELS)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .io_cmd_i(io_cmd_i), .io_cmd_v_i(io_cmd_v_i), .io_cmd_ready_o(io_cmd_ready_o),
    .mem_cmd_i(mem_cmd_i), .mem_cmd_v_i(mem_cmd_v_i), .mem_cmd_ready_o(mem_cmd_ready_o),
    .cmd_o(cmd_o), .cmd_v_o(cmd_v_o), .cmd_ready_i(cmd_ready_i),
    .resp_i(resp_i), .resp_v_i(resp_v_i), .resp_yumi_o(resp_yumi_o),
    .io_resp_o(io_resp_o), .io_resp_v_o(io_resp_v_o), .io_resp_ready_i(io_resp_ready_i),
    .mem_resp_o(mem_resp_o), .mem_resp_v_o(mem_resp_v_o), .mem_resp_ready_i(mem_resp_ready_i),
    .err_o(err_o),
    .perf_io_cnt_o(perf_io_cnt_o), .perf_mem_cnt_o(perf_mem_cnt_o),
    .perf_stall_cnt_o(perf_stall_cnt_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: issued-but-unanswered sources kept as a queue (0=io, 1=mem)
  bit           m_reg_v;
  logic [W-1:0] m_reg_data;
  bit           m_reg_src;
  bit           m_tags[$];
  bit           m_last_mem;
  bit           m_err;
  int unsigned  m_io_cnt, m_mem_cnt, m_stall_cnt;
  int           dut_accepts;

  function automatic void model_reset();
    m_reg_v = 0; m_reg_data = '0; m_reg_src = 0; m_tags.delete();
    m_last_mem = 1; m_err = 0; m_io_cnt = 0; m_mem_cnt = 0; m_stall_cnt = 0;
  endfunction

  // One cycle: drive at negedge, check #1 later, advance model, wait next negedge
  task automatic step(input bit iv, input bit mv, input bit cr, input bit rv,
                      input bit irr, input bit mrr);
    int  occ;
    bit  can, gi, gm, has, head, yumi, empty_before;
    io_cmd_v_i = iv; mem_cmd_v_i = mv; cmd_ready_i = cr; resp_v_i = rv;
    io_resp_ready_i = irr; mem_resp_ready_i = mrr;
    io_cmd_i = W'($urandom); mem_cmd_i = W'($urandom); resp_i = W'($urandom);
    #1;
    occ  = int'(m_reg_v) + m_tags.size();
    can  = (occ < ELS) && (!m_reg_v || cr);
    gi   = iv && (!mv || m_last_mem);
    gm   = mv && (!iv || !m_last_mem);
    has  = rv && (m_tags.size() > 0);
    head = has ? m_tags[0] : 1'b0;
    yumi = has && (head ? mrr : irr);

    check_val("cmd_v", 32'(cmd_v_o), 32'(m_reg_v));
    if (m_reg_v) check_val("cmd_data", 32'(cmd_o), 32'(m_reg_data));
    check_val("io_ready", 32'(io_cmd_ready_o), 32'(can && gi));
    check_val("mem_ready", 32'(mem_cmd_ready_o), 32'(can && gm));
    check_val("yumi", 32'(resp_yumi_o), 32'(yumi));
    check_val("io_resp_v", 32'(io_resp_v_o), 32'(has && !head));
    check_val("mem_resp_v", 32'(mem_resp_v_o), 32'(has && head));
    if (has && !head) check_val("io_resp_data", 32'(io_resp_o), 32'(resp_i));
    if (has && head)  check_val("mem_resp_data", 32'(mem_resp_o), 32'(resp_i));
    check_val("err", 32'(err_o), 32'(m_err));
    check_val("perf_io", perf_io_cnt_o, PERF ? m_io_cnt : 32'd0);
    check_val("perf_mem", perf_mem_cnt_o, PERF ? m_mem_cnt : 32'd0);
    check_val("perf_stall", perf_stall_cnt_o, PERF ? m_stall_cnt : 32'd0);

    if ((io_cmd_ready_o && iv) || (mem_cmd_ready_o && mv)) dut_accepts++;

    empty_before = (m_tags.size() == 0);
    if (m_reg_v && !cr) m_stall_cnt++;
    if (rv && empty_before) m_err = 1;
    if (yumi) void'(m_tags.pop_front());
    if (m_reg_v && cr) m_tags.push_back(m_reg_src);
    if (can && (gi || gm)) begin
      m_reg_v    = 1;
      m_reg_data = gi ? io_cmd_i : mem_cmd_i;
      m_reg_src  = gm;
      m_last_mem = gm;
      if (gi) m_io_cnt++; else m_mem_cnt++;
    end else if (m_reg_v && cr) begin
      m_reg_v = 0;
    end
    @(negedge clk);
  endtask

  // Apply reset with both command inputs asserted; ready must stay low
  task automatic do_reset();
    reset_i = 1'b1; io_cmd_v_i = 1'b1; mem_cmd_v_i = 1'b1; resp_v_i = 1'b0;
    #1;
    check_val("rst_cmd_v", 32'(cmd_v_o), 32'd0);
    check_val("rst_io_ready", 32'(io_cmd_ready_o), 32'd0);
    check_val("rst_mem_ready", 32'(mem_cmd_ready_o), 32'd0);
    check_val("rst_yumi", 32'(resp_yumi_o), 32'd0);
    check_val("rst_err", 32'(err_o), 32'd0);
    check_val("rst_perf_stall", perf_stall_cnt_o, 32'd0);
    @(negedge clk); @(negedge clk);
    io_cmd_v_i = 1'b0; mem_cmd_v_i = 1'b0;
    reset_i = 1'b0;
    model_reset();
    dut_accepts = 0;
  endtask

  initial begin
    model_reset();
    dut_accepts = 0;
    @(negedge clk);
    do_reset();

    // io-only burst of three, then three responses all routed to io
    repeat (3) step(1, 0, 1, 0, 1, 1);
    step(0, 0, 1, 0, 1, 1);
    repeat (3) step(0, 0, 1, 1, 1, 1);
    check_val("io_burst_accepts", 32'(dut_accepts), 32'd3);

    // Both valid: alternating grants, then drain responses
    repeat (8) step(1, 1, 1, 0, 1, 1);
    repeat (10) step(0, 0, 1, 1, 1, 1);

    // Fill to capacity with responses withheld
    do_reset();
    repeat (14) step(1, 1, 1, 0, 1, 1);
    check_val("full_accepts", 32'(dut_accepts), 32'd8);
    step(1, 0, 1, 1, 1, 1);
    check_val("full_pop_same_cycle", 32'(dut_accepts), 32'd8);
    step(1, 0, 1, 0, 1, 1);
    check_val("full_after_pop", 32'(dut_accepts), 32'd9);

    // Mem at head with mem_resp_ready low: response stalls
    do_reset();
    step(0, 1, 1, 0, 1, 1);
    step(1, 0, 1, 0, 1, 1);
    step(0, 0, 1, 0, 1, 1);
    repeat (3) step(0, 0, 1, 1, 1, 0);
    step(0, 0, 1, 1, 1, 1);
    step(0, 0, 1, 1, 1, 0);

    // Stall counter: five cycles of back-pressure
    do_reset();
    step(1, 0, 1, 0, 1, 1);
    repeat (5) step(0, 0, 0, 0, 1, 1);
    #1 check_val("stall_five", perf_stall_cnt_o, PERF ? 32'd5 : 32'd0);
    @(negedge clk);

    // Orphan response sets sticky err; reset clears it
    do_reset();
    step(0, 0, 1, 1, 1, 1);
    repeat (3) step(0, 0, 1, 0, 1, 1);
    #1 check_val("err_sticky", 32'(err_o), 32'd1);
    @(negedge clk);

    // Reset mid-operation, then a stale response flags err
    step(1, 1, 1, 0, 1, 1);
    step(1, 1, 1, 0, 1, 1);
    do_reset();
    step(0, 0, 1, 1, 1, 1);
    #1 check_val("err_after_midreset", 32'(err_o), 32'd1);
    @(negedge clk);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 3) != 0, ($urandom % 3) != 0, ($urandom % 4) != 0,
           (i > 20) && (($urandom % 5) < 3), ($urandom % 10) < 7, ($urandom % 10) < 7);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
